lsu_unit: RTL and testbench

//  Parametrised load/store unit for the MEM stage; replaces the single-cycle DPI access path.

---
 rtl/lsu_unit_if.sv | 41 ++++
 rtl/lsu_unit.sv | 126 ++++++++++++
 tb/tb_lsu_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_unit_if.sv
// Request, memory-bus and response signals of the load/store unit.
// The master modport is the core/bus side; the slave modport is the unit itself.
interface lsu_unit_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
);
    localparam int LANES = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_wen;
    logic [XLEN-1:0]   mem_req_wdata;
    logic [LANES-1:0]  mem_req_wmask;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rsp_rdata;

    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic [1:0]        rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  req_ready, mem_req_valid, mem_req_addr, mem_req_wen,
        input  mem_req_wdata, mem_req_wmask, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output req_ready, mem_req_valid, mem_req_addr, mem_req_wen,
        output mem_req_wdata, mem_req_wmask, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_unit.sv
// MEM-stage load/store unit: one outstanding access, lane alignment of stores,
// extraction/extension of loads, misaligned/oversize/timeout error reporting.
module lsu_unit #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input logic       clk,
    input logic       rst,
    lsu_unit_if.slave bus
);
    localparam int LANES = XLEN / 8;
    localparam int OFF_W = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    typedef struct packed {
        logic             store;
        logic             uns;
        logic [1:0]       size;
        logic [OFF_W-1:0] off;
    } op_t;

    state_t           state;
    op_t              cur;
    logic [CNT_W-1:0] cnt;

    logic [1:0]       in_size;
    logic [OFF_W-1:0] in_off;
    logic             in_misal;
    logic             in_oversize;
    logic [LANES-1:0] in_mask;

    // For size 3 the 3-bit alignment mask wraps to 3'b111, i.e. all low bits must be zero.
    always_comb begin
        in_size     = bus.req_op[1:0];
        in_off      = bus.req_addr[OFF_W-1:0];
        in_oversize = (XLEN == 32) && (in_size == 2'd3);
        in_misal    = (bus.req_addr[2:0] & ((3'd1 << in_size) - 3'd1)) != 3'd0;
        in_mask     = LANES'((9'd1 << (4'd1 << in_size)) - 9'd1) << in_off;
    end

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] msb;
    logic [XLEN-1:0] ld_data;
    logic [6:0]      nbits;

    // A full-width access shifts 1 out entirely, so keep becomes all ones and no extension occurs.
    always_comb begin
        shifted = bus.mem_rsp_rdata >> {cur.off, 3'b000};
        nbits   = 7'd8 << cur.size;
        keep    = (XLEN'(1) << nbits) - XLEN'(1);
        msb     = keep ^ (keep >> 1);
        ld_data = shifted & keep;
        if (!cur.uns && |(shifted & msb))
            ld_data = ld_data | ~keep;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            cur               <= '0;
            cnt               <= '0;
            bus.req_ready     <= 1'b1;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
            bus.mem_req_wen   <= 1'b0;
            bus.mem_req_wdata <= '0;
            bus.mem_req_wmask <= '0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_rdata     <= '0;
            bus.rsp_err       <= 2'd0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    cur           <= '{store: bus.req_op[3], uns: bus.req_op[2],
                                       size: in_size, off: in_off};
                    bus.req_ready <= 1'b0;
                    if (in_oversize || in_misal) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= in_oversize ? 2'd3 : 2'd1;
                    end else begin
                        state             <= REQ;
                        bus.mem_req_valid <= 1'b1;
                        bus.mem_req_addr  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bus.mem_req_wen   <= bus.req_op[3];
                        bus.mem_req_wdata <= bus.req_wdata << {in_off, 3'b000};
                        bus.mem_req_wmask <= bus.req_op[3] ? in_mask : '0;
                    end
                end
                REQ: if (bus.mem_req_ready) begin
                    bus.mem_req_valid <= 1'b0;
                    cnt               <= '0;
                    state             <= WAIT;
                end
                WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 2'd0;
                        bus.rsp_rdata <= cur.store ? '0 : ld_data;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 2'd2;
                        bus.rsp_rdata <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 2'd0;
                    bus.rsp_rdata <= '0;
                    bus.req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_unit.sv
// Bench for lsu_unit: a 64-bit and a 32-bit instance driven through one shared
// stimulus path, checked against an arithmetic reference model.
module tb_lsu_unit;
    localparam int T64 = 4;
    localparam int T32 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_unit_if #(.XLEN(64), .ADDR_W(64)) b64 ();
    lsu_unit_if #(.XLEN(32), .ADDR_W(32)) b32 ();

    lsu_unit #(.XLEN(64), .ADDR_W(64), .TIMEOUT(T64), .CNT_W(3))
        dut64 (.clk(clk), .rst(rst), .bus(b64.slave));
    lsu_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(T32), .CNT_W(2))
        dut32 (.clk(clk), .rst(rst), .bus(b32.slave));

    logic        sel;
    logic        r_valid, m_req_ready, m_rsp_valid;
    logic [3:0]  r_op;
    logic [63:0] r_addr, r_wdata, m_rdata;

    assign b64.req_valid     = r_valid & ~sel;
    assign b64.req_op        = r_op;
    assign b64.req_addr      = r_addr;
    assign b64.req_wdata     = r_wdata;
    assign b64.mem_req_ready = m_req_ready & ~sel;
    assign b64.mem_rsp_valid = m_rsp_valid & ~sel;
    assign b64.mem_rsp_rdata = m_rdata;
    assign b32.req_valid     = r_valid & sel;
    assign b32.req_op        = r_op;
    assign b32.req_addr      = r_addr[31:0];
    assign b32.req_wdata     = r_wdata[31:0];
    assign b32.mem_req_ready = m_req_ready & sel;
    assign b32.mem_rsp_valid = m_rsp_valid & sel;
    assign b32.mem_rsp_rdata = m_rdata[31:0];

    logic        o_ready, o_mvalid, o_wen, o_rvalid;
    logic [63:0] o_maddr, o_wdata, o_rdata;
    logic [7:0]  o_wmask;
    logic [1:0]  o_err;

    assign o_ready  = sel ? b32.req_ready     : b64.req_ready;
    assign o_mvalid = sel ? b32.mem_req_valid : b64.mem_req_valid;
    assign o_wen    = sel ? b32.mem_req_wen   : b64.mem_req_wen;
    assign o_rvalid = sel ? b32.rsp_valid     : b64.rsp_valid;
    assign o_maddr  = sel ? {32'd0, b32.mem_req_addr}  : b64.mem_req_addr;
    assign o_wdata  = sel ? {32'd0, b32.mem_req_wdata} : b64.mem_req_wdata;
    assign o_rdata  = sel ? {32'd0, b32.rsp_rdata}     : b64.rsp_rdata;
    assign o_wmask  = sel ? {4'd0, b32.mem_req_wmask}  : b64.mem_req_wmask;
    assign o_err    = sel ? b32.rsp_err : b64.rsp_err;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
        end
    endtask

    // Pick the addressed bytes, then sign-extend by the (v ^ s) - s identity.
    function automatic logic [63:0] ref_load(input logic [63:0] rd, input int off,
                                             input int size, input bit uns, input int xlen);
        logic [63:0] v, sb;
        int nb;
        nb = 8 << size;
        v  = rd >> (off * 8);
        if (nb < xlen) begin
            v = v & ((64'd1 << nb) - 64'd1);
            if (!uns) begin
                sb = 64'd1 << (nb - 1);
                v  = (v ^ sb) - sb;
            end
        end
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    // One transaction: rdly cycles of mem_req_ready low, response after sdly WAIT cycles.
    task automatic txn(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] rd, input int rdly, input int sdly);
        int          xlen, tmo, size, lanes, off;
        bit          st, uns;
        logic [1:0]  eerr;
        logic [63:0] xm, eaddr, emask, ewd;
        xlen  = sel ? 32 : 64;
        tmo   = sel ? T32 : T64;
        xm    = (xlen == 32) ? 64'hFFFF_FFFF : '1;
        size  = int'(op[1:0]);
        st    = op[3];
        uns   = op[2];
        lanes = xlen / 8;
        off   = int'(addr[2:0]) % lanes;
        if (xlen == 32 && size == 3)                    eerr = 2'd3;
        else if ((addr % (64'd1 << size)) != 64'd0)     eerr = 2'd1;
        else                                            eerr = 2'd0;

        chk("idle_ready", o_ready, 1);
        r_valid = 1'b1; r_op = op; r_addr = addr; r_wdata = wd;
        @(negedge clk);
        r_valid = 1'b0;
        if (eerr != 2'd0) begin
            chk("err_rvalid", o_rvalid, 1);
            chk("err_code", o_err, eerr);
            chk("err_rdata", o_rdata, 0);
            chk("err_no_bus", o_mvalid, 0);
            chk("err_busy", o_ready, 0);
            @(negedge clk);
            chk("err_pulse", o_rvalid, 0);
            return;
        end
        eaddr = addr & ~64'(lanes - 1) & xm;
        emask = st ? (((64'd1 << (1 << size)) - 64'd1) << off) : 64'd0;
        ewd   = ((wd & xm) << (off * 8)) & xm;
        for (int i = 0; i <= rdly; i++) begin
            // A response coinciding with acceptance must be ignored.
            m_req_ready = (i == rdly);
            m_rsp_valid = (i == rdly);
            m_rdata     = ~rd;
            chk("mvalid", o_mvalid, 1);
            chk("maddr", o_maddr, eaddr);
            chk("wen", o_wen, st);
            chk("wdata", o_wdata, ewd);
            chk("wmask", o_wmask, emask);
            chk("req_rvalid", o_rvalid, 0);
            @(negedge clk);
        end
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b0;
        chk("mvalid_drop", o_mvalid, 0);
        for (int i = 0; i < sdly && i < tmo; i++) begin
            chk("wait_rvalid", o_rvalid, 0);
            @(negedge clk);
        end
        if (sdly < tmo) begin
            m_rsp_valid = 1'b1;
            m_rdata     = rd;
            @(negedge clk);
            m_rsp_valid = 1'b0;
            chk("rvalid", o_rvalid, 1);
            chk("rsp_err", o_err, 0);
            chk("rdata", o_rdata, st ? 64'd0 : ref_load(rd, off, size, uns, xlen));
        end else begin
            chk("tmo_rvalid", o_rvalid, 1);
            chk("tmo_err", o_err, 2);
            chk("tmo_rdata", o_rdata, 0);
        end
        chk("resp_busy", o_ready, 0);
        @(negedge clk);
        chk("rvalid_pulse", o_rvalid, 0);
    endtask

    task automatic rand_txn(input int n);
        logic [3:0]  op;
        logic [63:0] addr;
        for (int k = 0; k < n; k++) begin
            op   = 4'($urandom_range(0, 15));
            addr = {32'($urandom), 32'($urandom)};
            if (sel) addr = addr & 64'hFFFF_FFFF;
            if ($urandom_range(0, 2) != 0)
                addr = addr & ~((64'd1 << op[1:0]) - 64'd1);
            txn(op, addr, {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                $urandom_range(0, 3), $urandom_range(0, 5));
        end
    endtask

    initial begin
        sel = 1'b0; r_valid = 1'b0; r_op = '0; r_addr = '0; r_wdata = '0;
        m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rdata = '0;
        rst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_ready", o_ready, 1);
            chk("rst_mvalid", o_mvalid, 0);
            chk("rst_maddr", o_maddr, 0);
            chk("rst_wen", o_wen, 0);
            chk("rst_wdata", o_wdata, 0);
            chk("rst_wmask", o_wmask, 0);
            chk("rst_rvalid", o_rvalid, 0);
            chk("rst_rdata", o_rdata, 0);
            chk("rst_err", o_err, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        txn(4'b0000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
        txn(4'b1001, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 64'd0, 0, 0);
        txn(4'b0010, 64'h8000_0002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        txn(4'b0011, 64'h8000_0000, 64'd0, 64'd0, 0, 99);
        chk("ready_after_tmo", o_ready, 1);
        txn(4'b0101, 64'h8000_0012, 64'd0, 64'hFEDC_BA98_7654_3210, 5, 1);

        // Reset pulsed in WAIT: no response, and a late bus response is dropped.
        r_valid = 1'b1; r_op = 4'b0010; r_addr = 64'h1000; r_wdata = '0;
        @(negedge clk);
        r_valid = 1'b0; m_req_ready = 1'b1;
        @(negedge clk);
        m_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_ready", o_ready, 1);
        chk("abort_mvalid", o_mvalid, 0);
        chk("abort_rvalid", o_rvalid, 0);
        @(negedge clk);
        rst = 1'b0; m_rsp_valid = 1'b1; m_rdata = 64'h1234;
        @(negedge clk);
        m_rsp_valid = 1'b0;
        chk("late_rsp_rvalid", o_rvalid, 0);
        chk("late_rsp_ready", o_ready, 1);
        @(negedge clk);
        chk("late_rsp_rvalid2", o_rvalid, 0);

        rand_txn(150);

        sel = 1'b1;
        @(negedge clk);
        txn(4'b0110, 64'h0000_0100, 64'd0, 64'h0000_0000_F000_0001, 0, 0);
        txn(4'b0010, 64'h0000_0104, 64'd0, 64'h0000_0000_F000_0001, 0, 0);
        txn(4'b0011, 64'h0000_0200, 64'd0, 64'd0, 0, 0);
        txn(4'b0000, 64'h0000_0303, 64'd0, 64'h0000_0000_8000_0000, 1, 0);
        txn(4'b1000, 64'h0000_0402, 64'h0000_0000_0000_00A5, 64'd0, 0, 9);
        rand_txn(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
